// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one subtract/restore step per clock,
// start/done handshake, quotient, remainder and divide-by-zero flag.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  div_q;
  logic [CW-1:0] cnt_q;

  logic [N+1:0]  rem_shift;
  logic [N+1:0]  trial;
  logic [N:0]    rem_next;
  logic [N-1:0]  quo_next;
  logic          last_iter;

  // The shifted remainder never reaches 2^(N+1), so bit N+1 of trial is a true sign bit.
  always_comb begin
    rem_shift = {rem_q, quo_q[N-1]};
    trial     = rem_shift - {2'b00, div_q};
    if (trial[N+1]) begin
      rem_next = rem_shift[N:0];
      quo_next = {quo_q[N-2:0], 1'b0};
    end else begin
      rem_next = trial[N:0];
      quo_next = {quo_q[N-2:0], 1'b1};
    end
    last_iter = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_next = (b == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Visible results change only on completion (or at acceptance for b == 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      y         <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              y         <= '1;
              remainder <= a;
              div_zero  <= 1'b1;
            end else begin
              quo_q <= a;
              div_q <= b;
              rem_q <= '0;
              cnt_q <= '0;
            end
          end
        end
        RUN: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            y         <= quo_next;
            remainder <= rem_next[N-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at N=32, plus a held-start
// throughput check on an N=8 instance.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] y32, rem32;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  y8, rem8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .y(y32), .remainder(rem32), .div_zero(dz32)
  );

  seq_divider #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8), .remainder(rem8), .div_zero(dz8)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the divider idle; returns one negedge later.
  task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv);
    a32     = av;
    b32     = bv;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = busy32 ? 1 : 0;
    while (!done32 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy32) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input logic [31:0] exp_y,
                        input logic [31:0] exp_rem, input logic exp_dz, output int bcnt);
    int lat;
    apply_stimulus(av, bv);
    wait_done(1, lat, bcnt);
    check_output({tag, ".latency"}, lat, exp_lat);
    check_output({tag, ".done"}, done32, 1'b1);
    check_output({tag, ".y"}, y32, exp_y);
    check_output({tag, ".rem"}, rem32, exp_rem);
    check_output({tag, ".dz"}, dz32, exp_dz);
    @(negedge clk);
  endtask

  initial begin
    int bcnt;
    int lat;
    logic [31:0] av, bv;

    @(negedge clk);
    check_output("rst.busy", busy32, 1'b0);
    check_output("rst.done", done32, 1'b0);
    check_output("rst.y", y32, 32'h0);
    check_output("rst.rem", rem32, 32'h0);
    check_output("rst.dz", dz32, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    run_op("d100_7", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, bcnt);
    check_output("d100_7.busy_cycles", bcnt, 33);
    check_output("d100_7.busy_after", busy32, 1'b0);
    check_output("d100_7.done_after", done32, 1'b0);

    run_op("d5_9", 32'd5, 32'd9, 33, 32'd0, 32'd5, 1'b0, bcnt);
    run_op("d0_7", 32'd0, 32'd7, 33, 32'd0, 32'd0, 1'b0, bcnt);
    run_op("dmax_1", 32'hFFFFFFFF, 32'd1, 33, 32'hFFFFFFFF, 32'd0, 1'b0, bcnt);
    run_op("dmax_maxm1", 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32'd1, 32'd1, 1'b0, bcnt);
    run_op("d1234_0", 32'd1234, 32'd0, 1, 32'hFFFFFFFF, 32'd1234, 1'b1, bcnt);
    check_output("d1234_0.busy_cycles", bcnt, 1);
    run_op("d9_3", 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, bcnt);

    // A second start in the middle of RUN must not be sampled.
    apply_stimulus(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    a32     = 32'd50;
    b32     = 32'd5;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    check_output("ign.busy_mid", busy32, 1'b1);
    check_output("ign.y_held", y32, 32'd3);
    check_output("ign.rem_held", rem32, 32'd0);
    wait_done(6, lat, bcnt);
    check_output("ign.latency", lat, 33);
    check_output("ign.y", y32, 32'd14);
    check_output("ign.rem", rem32, 32'd2);
    @(negedge clk);
    @(negedge clk);
    check_output("ign.no_queue", busy32, 1'b0);

    // Asynchronous reset partway through RUN.
    apply_stimulus(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("arst.busy", busy32, 1'b0);
    check_output("arst.done", done32, 1'b0);
    check_output("arst.y", y32, 32'h0);
    check_output("arst.rem", rem32, 32'h0);
    check_output("arst.dz", dz32, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("d81_9", 32'd81, 32'd9, 33, 32'd9, 32'd0, 1'b0, bcnt);

    // N=8 with start held high: first result after 9 negedges, then every 10.
    a8     = 8'd200;
    b8     = 8'd13;
    start8 = 1'b1;
    for (int op = 0; op < 3; op++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!done8 && lat < 40);
      check_output($sformatf("n8.interval%0d", op), lat, (op == 0) ? 9 : 10);
      check_output($sformatf("n8.y%0d", op), y8, 8'd15);
      check_output($sformatf("n8.rem%0d", op), rem8, 8'd5);
      check_output($sformatf("n8.dz%0d", op), dz8, 1'b0);
    end
    start8 = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      av = $urandom;
      bv = $urandom >> $urandom_range(0, 31);
      if (bv == 0) bv = 32'd1;
      apply_stimulus(av, bv);
      wait_done(1, lat, bcnt);
      check_output("rnd.y", y32, av / bv);
      check_output("rnd.rem", rem32, av % bv);
      check_output("rnd.invariant", ({32'h0, y32} * {32'h0, bv}) + {32'h0, rem32}, {32'h0, av});
      check_output("rnd.rem_lt_b", rem32 < bv, 1'b1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
